// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32E instruction fetch stage. Holds the program counter, issues
//            word-aligned requests to instruction memory (one outstanding at
//            a time) and buffers returned words with their PCs in a 2-entry
//            queue toward decode. A taken branch redirects the PC, flushes the
//            queue and discards any response still in flight.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            branch_taken, branch_addr     - redirect request / target
//            imem_req_valid/addr/ready     - fetch request handshake
//            imem_resp_valid/data          - returned instruction word
//            inst_valid, inst, inst_pc     - queue head toward decode
//            inst_ready                    - decode consumes the head
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_INIT    = RESET_PC & ALIGN_MASK;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;       // address of the request currently outstanding
  logic [1:0]  count;
  logic        outstanding;
  logic        active;       // low while in reset so no request is offered then
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];

  logic        can_req;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic        wr_idx;
  logic [31:0] branch_target;

  assign branch_target = branch_addr & ALIGN_MASK;

  // Request eligibility is purely registered; branch_taken only gates it so
  // no request is ever accepted at the stale PC in the redirect cycle.
  assign can_req        = active && (state == S_FETCH) &&
                          (({1'b0, count} + {2'b00, outstanding}) < 3'd2);
  assign imem_req_valid = can_req && !branch_taken;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are only kept in WAIT; DISCARD and FETCH drop them.
  assign push = imem_resp_valid && (state == S_WAIT) && !branch_taken;

  assign inst_valid = (count != 2'd0);
  assign inst       = fifo_inst[0];
  assign inst_pc    = fifo_pc[0];
  assign pop        = inst_valid && inst_ready;

  // Slot 0 is always the head. A push lands in slot count, or one slot lower
  // when the head shifts out in the same cycle: that works out to count[0]
  // without a pop and count[1] with one (push never happens at count 2).
  assign wr_idx = pop ? count[1] : count[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= PC_INIT;
      req_pc       <= 32'h0;
      count        <= 2'd0;
      outstanding  <= 1'b0;
      active       <= 1'b0;
      fifo_pc[0]   <= 32'h0;
      fifo_pc[1]   <= 32'h0;
      fifo_inst[0] <= 32'h0;
      fifo_inst[1] <= 32'h0;
    end else begin
      active <= 1'b1;
      if (branch_taken) begin
        pc    <= branch_target;
        count <= 2'd0;
        // A response still owed to us must be swallowed before refetching.
        if (outstanding && !imem_resp_valid) begin
          state <= S_DISCARD;
        end else begin
          state       <= S_FETCH;
          outstanding <= 1'b0;
        end
      end else begin
        case (state)
          S_FETCH: begin
            if (req_fire) begin
              pc          <= pc + 32'd4;
              req_pc      <= pc;
              outstanding <= 1'b1;
              state       <= S_WAIT;
            end
          end
          S_WAIT, S_DISCARD: begin
            if (imem_resp_valid) begin
              outstanding <= 1'b0;
              state       <= S_FETCH;
            end
          end
          default: state <= S_FETCH;
        endcase

        if (pop) begin
          fifo_pc[0]   <= fifo_pc[1];
          fifo_inst[0] <= fifo_inst[1];
        end
        if (push) begin
          fifo_pc[wr_idx]   <= req_pc;
          fifo_inst[wr_idx] <= imem_resp_data;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit. A memory model with
//            programmable latency answers requests; accepted requests are
//            pushed to a scoreboard and popped when decode takes an entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Second instance used only to observe PC wrap-around.
  logic        branch_taken2;
  logic [31:0] branch_addr2;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        req_ready2;
  logic        resp_valid2;
  logic [31:0] resp_data2;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;
  logic        inst_ready2;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req_valid  (req_valid),
    .imem_req_addr   (req_addr),
    .imem_req_ready  (req_ready),
    .imem_resp_valid (resp_valid),
    .imem_resp_data  (resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .branch_taken    (branch_taken2),
    .branch_addr     (branch_addr2),
    .imem_req_valid  (req_valid2),
    .imem_req_addr   (req_addr2),
    .imem_req_ready  (req_ready2),
    .imem_resp_valid (resp_valid2),
    .imem_resp_data  (resp_data2),
    .inst_valid      (inst_valid2),
    .inst            (inst2),
    .inst_pc         (inst_pc2),
    .inst_ready      (inst_ready2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory model (main DUT) ----------------
  int          mem_lat = 1;
  bit          mem_armed;
  int          mem_timer;
  logic [31:0] mem_addr;

  initial begin
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    mem_armed  = 1'b0;
    mem_timer  = 0;
    mem_addr   = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        mem_armed = 1'b1;
        mem_timer = mem_lat;
        mem_addr  = req_addr;
      end
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
      if (mem_armed) begin
        mem_timer = mem_timer - 1;
        if (mem_timer == 0) begin
          resp_valid = 1'b1;
          resp_data  = data_of(mem_addr);
          mem_armed  = 1'b0;
        end
      end
    end
  end

  // ---------------- memory model (wrap DUT) ----------------
  logic [31:0] q2[$];
  bit          acc2;
  initial begin
    branch_taken2 = 1'b0;
    branch_addr2  = 32'h0;
    req_ready2    = 1'b1;
    inst_ready2   = 1'b1;
    resp_valid2   = 1'b0;
    resp_data2    = 32'h0000_0013;
    acc2          = 1'b0;
    forever begin
      @(negedge clk);
      acc2 = !rst && (req_valid2 === 1'b1);
      if (acc2 && q2.size() < 2) q2.push_back(req_addr2);
      @(posedge clk);
      #1;
      resp_valid2 = acc2;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [63:0] sb[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (inst_valid && inst_ready) begin
        got_q.push_back({inst_pc, inst});
        if (sb.size() > 0) exp_q.push_back(sb.pop_front());
        else               exp_q.push_back('x);
      end
      if (branch_taken) sb.delete();
      if (req_valid && req_ready) begin
        sb.push_back({req_addr, data_of(req_addr)});
        req_addr_log.push_back(req_addr);
        req_cyc_log.push_back(cyc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  int cmp_idx = 0;
  task automatic compare_pops();
    for (; cmp_idx < got_q.size(); cmp_idx++) begin
      chk("pop_pc",   got_q[cmp_idx][63:32], exp_q[cmp_idx][63:32]);
      chk("pop_inst", got_q[cmp_idx][31:0],  exp_q[cmp_idx][31:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int base_r;
  int base_g;
  int first_iv;

  initial begin
    rst          = 1'b1;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    req_ready    = 1'b1;
    inst_ready   = 1'b1;
    tick(3);

    // Reset values
    @(negedge clk);
    chk("rst_req_valid",  {31'b0, req_valid},  32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst",       inst,                32'h0);
    chk("rst_inst_pc",    inst_pc,             32'h0);
    chk("rst_req_addr",   req_addr,            32'h0000_0100);

    // Streaming with 1-cycle memory and decode always ready
    base_r   = req_addr_log.size();
    base_g   = got_q.size();
    first_iv = -1;
    tick(1);
    rst = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (inst_valid && first_iv < 0) first_iv = cyc;
    end
    chk("t1_req_count_ok", {31'b0, (req_addr_log.size() - base_r) >= 3}, 32'd1);
    if (req_addr_log.size() - base_r >= 3) begin
      chk("t1_req0", req_addr_log[base_r],     32'h0000_0100);
      chk("t1_req1", req_addr_log[base_r + 1], 32'h0000_0104);
      chk("t1_req2", req_addr_log[base_r + 2], 32'h0000_0108);
      chk("t1_gap01", req_cyc_log[base_r + 1] - req_cyc_log[base_r],     32'd2);
      chk("t1_gap12", req_cyc_log[base_r + 2] - req_cyc_log[base_r + 1], 32'd2);
      chk("t1_latency", first_iv - req_cyc_log[base_r], 32'd2);
    end
    chk("t1_pop_count_ok", {31'b0, (got_q.size() - base_g) >= 3}, 32'd1);
    if (got_q.size() - base_g >= 3) begin
      chk("t1_pop0_pc", got_q[base_g][63:32],     32'h0000_0100);
      chk("t1_pop1_pc", got_q[base_g + 1][63:32], 32'h0000_0104);
      chk("t1_pop2_pc", got_q[base_g + 2][63:32], 32'h0000_0108);
    end

    // PC wrap observed on the second instance
    chk("wrap_count_ok", {31'b0, q2.size() >= 2}, 32'd1);
    if (q2.size() >= 2) begin
      chk("wrap_req0", q2[0], 32'hFFFF_FFFC);
      chk("wrap_req1", q2[1], 32'h0000_0000);
    end

    // Full queue back-pressure
    tick(1);
    rst        = 1'b1;
    inst_ready = 1'b0;
    tick(2);
    rst    = 1'b0;
    base_r = req_addr_log.size();
    repeat (12) @(negedge clk);
    chk("t2_req_count",  req_addr_log.size() - base_r, 32'd2);
    chk("t2_req_idle",   {31'b0, req_valid},  32'd0);
    chk("t2_inst_valid", {31'b0, inst_valid}, 32'd1);
    tick(1);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    @(negedge clk);
    chk("t2_reissue_valid", {31'b0, req_valid}, 32'd1);
    chk("t2_reissue_addr",  req_addr,           32'h0000_0108);
    repeat (6) @(negedge clk);
    chk("t2_req_count2", req_addr_log.size() - base_r, 32'd3);
    chk("t2_req_idle2",  {31'b0, req_valid}, 32'd0);

    // Redirect while waiting on a slow response
    tick(1);
    rst        = 1'b1;
    inst_ready = 1'b1;
    req_ready  = 1'b0;
    mem_lat    = 3;
    tick(2);
    rst = 1'b0;
    tick(2);
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0200;
    @(negedge clk);
    chk("t3_redirect_gate", {31'b0, req_valid}, 32'd0);
    tick(1);
    branch_taken = 1'b0;
    req_ready    = 1'b1;
    @(negedge clk);
    chk("t3_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t3_req_addr",  req_addr,           32'h0000_0200);
    tick(1);
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0403;
    @(negedge clk);
    chk("t3_wait_idle", {31'b0, req_valid}, 32'd0);
    tick(1);
    branch_taken = 1'b0;
    @(negedge clk);
    chk("t3_discard_idle1", {31'b0, req_valid}, 32'd0);
    @(negedge clk);
    chk("t3_discard_idle2", {31'b0, req_valid},  32'd0);
    chk("t3_no_inst",       {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("t3_target_valid", {31'b0, req_valid},  32'd1);
    chk("t3_target_addr",  req_addr,            32'h0000_0400);
    chk("t3_no_inst2",     {31'b0, inst_valid}, 32'd0);
    repeat (10) @(negedge clk);

    // Redirect coinciding with the response
    tick(1);
    rst     = 1'b1;
    mem_lat = 1;
    tick(2);
    rst = 1'b0;
    wait_accept("t4_accept_seen");
    tick(1);
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0300;
    tick(1);
    branch_taken = 1'b0;
    @(negedge clk);
    chk("t4_req_valid", {31'b0, req_valid},  32'd1);
    chk("t4_req_addr",  req_addr,            32'h0000_0300);
    chk("t4_no_inst",   {31'b0, inst_valid}, 32'd0);
    repeat (8) @(negedge clk);

    // Reset while discarding; late response must be ignored
    tick(1);
    rst     = 1'b1;
    mem_lat = 4;
    tick(2);
    rst = 1'b0;
    wait_accept("t6_accept_seen");
    tick(1);
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0500;
    req_ready    = 1'b0;
    tick(1);
    branch_taken = 1'b0;
    rst          = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t6_rst_req_valid",  {31'b0, req_valid},  32'd0);
    chk("t6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_rst_inst",       inst,                32'h0);
    chk("t6_rst_inst_pc",    inst_pc,             32'h0);
    chk("t6_rst_req_addr",   req_addr,            32'h0000_0100);
    tick(1);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    chk("t6_after_req_valid", {31'b0, req_valid},  32'd1);
    chk("t6_after_req_addr",  req_addr,            32'h0000_0100);
    chk("t6_after_no_inst",   {31'b0, inst_valid}, 32'd0);
    tick(1);
    req_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Drain and compare everything decode received
    tick(1);
    req_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("final_sb_empty",    sb.size(), 32'd0);
    chk("final_inst_idle",   {31'b0, inst_valid}, 32'd0);
    compare_pops();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
